// File: rtl/bcd_pkg.sv
// Shared constants and types for the shared bin2bcd converter front end.
// The tag id width covers the largest supported requester count.
package bcd_pkg;

  localparam int BCD_BIN_W = 11;
  localparam int BCD_OUT_W = 17;
  localparam int BCD_LAT   = 6;
  localparam int BCD_ID_W  = 3;

  typedef struct packed {
    logic                v;
    logic [BCD_ID_W-1:0] id;
  } tag_t;

  // Advance a round-robin index with wrap at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first request at or after the pointer wins;
// the pointer moves just past the winner when a grant is issued.
module rr_arbiter
  import bcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0]  ptr_r;
  logic [NREQ-1:0] req_m_s;
  logic [IDW-1:0]  idx_s;
  logic            hit_s;

  // Priority scan starting at the pointer; grants are blocked while disabled or in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    req_m_s = (en && !rst) ? req : '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s      = IDW'((int'(ptr_r) + k) % NREQ);
      hit_s      = req_m_s[idx_s] & ~gnt_any;
      gnt_idx    = hit_s ? idx_s : gnt_idx;
      gnt[idx_s] = gnt[idx_s] | hit_s;
      gnt_any    = gnt_any | hit_s;
    end
  end

  // Pointer only moves on an actual grant, so a paused stream resumes fairly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (gnt_any) begin
      ptr_r <= IDW'(wrap_inc(int'(gnt_idx), NREQ));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one fixed-latency bin2bcd converter between NREQ requesters and
// routes each result back with the id of the requester that issued it.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = BCD_LAT,
  parameter int IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*BCD_BIN_W-1:0] req_bin,
  output logic [NREQ-1:0]           req_ready,
  output logic [BCD_BIN_W-1:0]      cv_bin,
  output logic                      cv_vid,
  input  logic [BCD_OUT_W-1:0]      cv_bcd,
  input  logic                      cv_bcd_vid,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [BCD_OUT_W-1:0]      rsp_bcd,
  output logic                      busy,
  output logic                      err
);

  logic [IDW-1:0] gnt_idx_s;
  logic           gnt_any_s;
  logic [IDW-1:0] cv_id_r;
  tag_t           tag_r [LAT];

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req_valid),
    .gnt    (req_ready),
    .gnt_idx(gnt_idx_s),
    .gnt_any(gnt_any_s)
  );

  // Issue register, tag pipe aligned to the converter output, and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_vid    <= 1'b0;
      cv_bin    <= '0;
      cv_id_r   <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_r[k] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bcd   <= '0;
      err       <= 1'b0;
    end else begin
      cv_vid  <= gnt_any_s;
      cv_bin  <= gnt_any_s ? req_bin[int'(gnt_idx_s)*BCD_BIN_W +: BCD_BIN_W] : '0;
      cv_id_r <= gnt_any_s ? gnt_idx_s : '0;
      // Entry 0 captures the operand the converter samples on this edge.
      tag_r[0] <= tag_t'{v: cv_vid, id: BCD_ID_W'(cv_id_r)};
      for (int k = 1; k < LAT; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
      rsp_valid <= cv_bcd_vid & tag_r[LAT-1].v;
      rsp_id    <= IDW'(tag_r[LAT-1].id);
      rsp_bcd   <= (cv_bcd_vid & tag_r[LAT-1].v) ? cv_bcd : '0;
      err       <= err | (cv_bcd_vid != tag_r[LAT-1].v);
    end
  end

  // Anything between the issue register and the tail of the tag pipe counts as in flight.
  always_comb begin
    busy = cv_vid;
    for (int k = 0; k < LAT; k++) begin
      busy = busy | tag_r[k].v;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: behavioural converter plus a queue-based
// reference of grants and expected responses, directed and random phases.
module tb_bcd_conv_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 6;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*11-1:0] req_bin;
  logic [NREQ-1:0]  req_ready;
  logic [10:0]      cv_bin;
  logic             cv_vid;
  logic [16:0]      cv_bcd;
  logic             cv_bcd_vid;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [16:0]      rsp_bcd;
  logic             busy;
  logic             err;

  bcd_conv_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .cv_bin(cv_bin), .cv_vid(cv_vid), .cv_bcd(cv_bcd),
    .cv_bcd_vid(cv_bcd_vid), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_bcd(rsp_bcd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] to_bcd(input logic [10:0] b);
    int v, m;
    v = int'($signed(b));
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Converter: LAT-stage pipe, reset together with the arbiter; force_vid injects a stray result.
  logic        c_v   [LAT];
  logic [16:0] c_bcd [LAT];
  logic        force_vid;
  assign cv_bcd_vid = c_v[LAT-1] | force_vid;
  assign cv_bcd     = c_bcd[LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        c_v[k]   <= 1'b0;
        c_bcd[k] <= 17'd0;
      end
    end else begin
      c_v[0]   <= cv_vid;
      c_bcd[0] <= cv_vid ? to_bcd(cv_bin) : 17'd0;
      for (int k = 1; k < LAT; k++) begin
        c_v[k]   <= c_v[k-1];
        c_bcd[k] <= c_bcd[k-1];
      end
    end
  end

  typedef struct {
    int          id;
    logic [16:0] bcd;
    int          g;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          ptr_m = 0;
  int          cyc = 0;
  logic        exp_cv_vid = 1'b0;
  logic [10:0] exp_cv_bin = 11'd0;
  logic        exp_err = 1'b0;
  int          errors = 0;
  int          checks = 0;

  int          last_g_cyc = -1;
  int          seen_id = -1;
  logic [16:0] seen_bcd = 17'd0;
  int          seen_cyc = -1;
  int          rsp_count = 0;
  int          dut_gnt_log[$];
  int          rsp_id_log[$];
  int          rsp_cyc_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst || !en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: compare at the falling edge, then advance the reference at the rising edge.
  task automatic cycle();
    int          g;
    int          dg;
    logic        due_now;
    logic        exp_busy;
    logic        real_v;
    @(negedge clk);
    g = exp_grant();
    check("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    dg = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) dg = i;
    if (dg >= 0) dut_gnt_log.push_back(dg);
    check("cv_vid", 32'(cv_vid), 32'(exp_cv_vid));
    check("cv_bin", 32'(cv_bin), 32'(exp_cv_bin));
    due_now = (q.size() > 0) && (q[0].due == cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(due_now));
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      seen_id  = int'(rsp_id);
      seen_bcd = rsp_bcd;
      seen_cyc = cyc;
      rsp_id_log.push_back(int'(rsp_id));
      rsp_cyc_log.push_back(cyc);
    end
    if (due_now) begin
      check("rsp_id", 32'(rsp_id), 32'(q[0].id));
      check("rsp_bcd", 32'(rsp_bcd), 32'(q[0].bcd));
      void'(q.pop_front());
    end else begin
      check("rsp_bcd_idle", 32'(rsp_bcd), 32'd0);
    end
    exp_busy = 1'b0;
    foreach (q[i]) if (q[i].g < cyc) exp_busy = 1'b1;
    check("busy", 32'(busy), 32'(exp_busy));
    check("err", 32'(err), 32'(exp_err));
    @(posedge clk);
    if (rst) begin
      q.delete();
      ptr_m      = 0;
      exp_cv_vid = 1'b0;
      exp_cv_bin = 11'd0;
      exp_err    = 1'b0;
    end else begin
      real_v = 1'b0;
      foreach (q[i]) if (q[i].due == cyc + 1) real_v = 1'b1;
      if (force_vid && !real_v) exp_err = 1'b1;
      if (g >= 0) begin
        q.push_back('{id: g, bcd: to_bcd(req_bin[g*11 +: 11]), g: cyc, due: cyc + LAT + 2});
        ptr_m      = (g + 1) % NREQ;
        exp_cv_vid = 1'b1;
        exp_cv_bin = req_bin[g*11 +: 11];
        last_g_cyc = cyc;
      end else begin
        exp_cv_vid = 1'b0;
        exp_cv_bin = 11'd0;
      end
    end
    #1;
    cyc++;
  endtask

  initial begin
    int t1_g;
    int saved;
    int cnt0;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_bin = '0; force_vid = 1'b0;
    repeat (2) cycle();
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0; en = 1'b1;

    // 1: single request, positive operand
    req_valid = 4'b0001; req_bin[10:0] = 11'd999;
    cycle();
    t1_g = last_g_cyc;
    req_valid = '0;
    repeat (LAT + 3) cycle();
    check("t1_id", 32'(seen_id), 32'd0);
    check("t1_bcd", 32'(seen_bcd), 32'h00999);
    check("t1_lat", 32'(seen_cyc - t1_g), 32'(LAT + 2));

    // 2: negative operand from requester 2
    req_valid = 4'b0100; req_bin[32:22] = 11'h7FB;
    cycle();
    req_valid = '0;
    repeat (LAT + 3) cycle();
    check("t2_id", 32'(seen_id), 32'd2);
    check("t2_bcd", 32'(seen_bcd), 32'h10005);

    // 3: full load from ptr=0 (requester 3 first moves the pointer to 0)
    req_valid = 4'b1000; req_bin[43:33] = 11'd5;
    cycle();
    req_valid = '0;
    repeat (LAT + 3) cycle();
    dut_gnt_log.delete(); rsp_id_log.delete(); rsp_cyc_log.delete();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      req_bin = {11'(i * 37), 11'(1000 - i), 11'(11'h400 + i), 11'(i)};
      cycle();
    end
    req_valid = '0;
    repeat (LAT + 3) cycle();
    check("t3_ngnt", 32'(dut_gnt_log.size()), 32'd8);
    check("t3_nrsp", 32'(rsp_id_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dut_gnt_log.size()) check("t3_gnt_order", 32'(dut_gnt_log[i]), 32'(i % 4));
      if (i < rsp_id_log.size()) begin
        check("t3_rsp_order", 32'(rsp_id_log[i]), 32'(i % 4));
        check("t3_rsp_gap", 32'(rsp_cyc_log[i] - rsp_cyc_log[0]), 32'(i));
      end
    end

    // 4: disable mid-stream, drain, resume at saved pointer
    dut_gnt_log.delete();
    req_valid = 4'hF;
    repeat (3) cycle();
    saved = (dut_gnt_log.size() > 0) ? (dut_gnt_log[dut_gnt_log.size() - 1] + 1) % NREQ : -1;
    en = 1'b0;
    repeat (LAT + 4) cycle();
    check("t4_busy_drained", 32'(busy), 32'd0);
    check("t4_ready_off", 32'(req_ready), 32'd0);
    dut_gnt_log.delete();
    en = 1'b1;
    cycle();
    check("t4_resume", (dut_gnt_log.size() > 0) ? 32'(dut_gnt_log[0]) : 32'hFFFF, 32'(saved));
    req_valid = '0;
    repeat (LAT + 3) cycle();

    // 5: reset with three conversions in flight
    req_valid = 4'hF;
    repeat (3) cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cnt0 = rsp_count;
    cycle();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    repeat (LAT + 4) cycle();
    check("t5_no_rsp", 32'(rsp_count - cnt0), 32'd0);

    // random traffic with occasional enable drops and resets
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      req_bin   = {11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom)};
      en        = ($urandom_range(0, 7) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b0; req_valid = '0;
    repeat (LAT + 4) cycle();

    // 6: stray converter result with an empty tag pipe
    cnt0 = rsp_count;
    force_vid = 1'b1;
    cycle();
    force_vid = 1'b0;
    repeat (5) cycle();
    check("t6_err_sticky", 32'(err), 32'd1);
    check("t6_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("t6_err_cleared", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
